// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//  - arb_state_e : arbiter FSM states
//  - owner_e     : which requester owns the current access
//  - BEATS/BYTE_W: a 32-bit word is moved as 4 byte beats, big-endian
//  - addr_illegal: misaligned or out-of-range word base check
//  - word_byte   : select the byte of a word carried on a given beat
package mem_arb_pkg;

  localparam int BEATS  = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } owner_e;

  // A word access is legal only if aligned and all four bytes fit in the array.
  function automatic logic addr_illegal(input logic [WORD_W-1:0] addr,
                                        input int unsigned       depth);
    return (addr[1:0] != 2'b00) || (addr > (depth - 32'd4));
  endfunction

  // Big-endian: beat 0 carries bits [31:24], beat 3 carries bits [7:0].
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        beat);
    return w[BYTE_W*(BEATS-1-int'(beat)) +: BYTE_W];
  endfunction

endpackage

// File: rtl/mem_beat_seq.sv
// Byte beat sequencer for one granted word access.
// Ports:
//  clk, rst_n   : clock, async active-low reset
//  start        : 1-cycle pulse at grant; clears beat counter and read word
//  active       : high while the arbiter is in ACCESS
//  we           : 1 = store, 0 = load (latched by the arbiter)
//  base         : word base byte address (latched by the arbiter)
//  wdata        : store word (latched by the arbiter)
//  mem_rbyte    : combinational read byte from the array
//  mem_addr/mem_we/mem_wbyte : array pins, all zero when not active
//  rdata        : assembled load word
//  last_beat    : high during the final beat
module mem_beat_seq
  import mem_arb_pkg::*;
#(
  parameter int MADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               active,
  input  logic               we,
  input  logic [MADDR_W-1:0] base,
  input  logic [31:0]        wdata,
  input  logic [7:0]         mem_rbyte,
  output logic [MADDR_W-1:0] mem_addr,
  output logic               mem_we,
  output logic [7:0]         mem_wbyte,
  output logic [31:0]        rdata,
  output logic               last_beat
);

  logic [1:0]  beat_q, beat_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    beat_d    = beat_q;
    rdata_d   = rdata_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wbyte = '0;
    last_beat = 1'b0;
    if (start) begin
      beat_d  = 2'd0;
      rdata_d = '0;
    end else if (active) begin
      // The adder wraps modulo 2**MADDR_W; the arbiter's range check
      // guarantees a real wrap never happens.
      mem_addr  = base + MADDR_W'(beat_q);
      mem_we    = we;
      mem_wbyte = we ? word_byte(wdata, beat_q) : 8'h00;
      if (!we) begin
        rdata_d[BYTE_W*(BEATS-1-int'(beat_q)) +: BYTE_W] = mem_rbyte;
      end
      beat_d    = beat_q + 2'd1;
      last_beat = (beat_q == 2'(BEATS-1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= 2'd0;
      rdata_q <= '0;
    end else begin
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single byte-wide data memory between instruction fetch (IF)
// and load/store (DM). Each granted word becomes 4 big-endian byte beats.
// Ports:
//  clk, rst_n                      : clock, async active-low reset
//  if_req/if_addr                  : IF read request (level, held until if_done)
//  if_done/if_rdata/if_err         : IF response, 1-cycle pulse
//  dm_req/dm_we/dm_addr/dm_wdata   : DM request (level, held until dm_done)
//  dm_done/dm_rdata/dm_err         : DM response, 1-cycle pulse
//  mem_addr/mem_we/mem_wbyte       : array pins (array writes on same posedge)
//  mem_rbyte                       : combinational array read byte
//  busy                            : high whenever not IDLE
//  dbg_state                       : current FSM state encoding
// Handshake: a requester raises req and holds it with stable inputs until it
// sees its done pulse, and drops req in that same done cycle. Inputs are
// latched at grant, so later changes are ignored until done.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int MADDR_W    = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic               if_done,
  output logic [31:0]        if_rdata,
  output logic               if_err,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [31:0]        dm_addr,
  input  logic [31:0]        dm_wdata,
  output logic               dm_done,
  output logic [31:0]        dm_rdata,
  output logic               dm_err,
  output logic [MADDR_W-1:0] mem_addr,
  output logic               mem_we,
  output logic [7:0]         mem_wbyte,
  input  logic [7:0]         mem_rbyte,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e         state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [MADDR_W-1:0] base_q, base_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [SW-1:0]      starve_q, starve_d;

  logic               seq_start;
  logic               pick_if;
  logic [31:0]        sel_addr;
  logic               last_beat;
  logic [31:0]        seq_rdata;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    base_d    = base_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    starve_d  = starve_q;
    seq_start = 1'b0;
    pick_if   = 1'b0;
    sel_addr  = '0;
    case (state_q)
      ST_IDLE: begin
        // No IF waiting means nobody is being starved.
        if (!if_req) starve_d = '0;
        if (if_req || dm_req) begin
          // DM normally wins a tie; IF is forced once it has lost
          // STARVE_MAX consecutive ties.
          pick_if  = if_req && (!dm_req || (starve_q == SW'(STARVE_MAX)));
          sel_addr = pick_if ? if_addr : dm_addr;
          owner_d  = pick_if ? OWNER_IF : OWNER_DM;
          we_d     = pick_if ? 1'b0 : dm_we;
          wdata_d  = pick_if ? 32'h0 : dm_wdata;
          base_d   = sel_addr[MADDR_W-1:0];
          if (pick_if) begin
            starve_d = '0;
          end else if (if_req && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
          end
          seq_start = 1'b1;
          state_d   = addr_illegal(sel_addr, MEM_DEPTH) ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (last_beat) state_d = ST_RESP;
      end
      ST_RESP:   state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWNER_IF;
      base_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      base_q   <= base_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

  mem_beat_seq #(
    .MADDR_W (MADDR_W)
  ) u_beat_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (seq_start),
    .active    (state_q == ST_ACCESS),
    .we        (we_q),
    .base      (base_q),
    .wdata     (wdata_q),
    .mem_rbyte (mem_rbyte),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wbyte (mem_wbyte),
    .rdata     (seq_rdata),
    .last_beat (last_beat)
  );

  // Responses are decoded from state so they drop together with an async reset.
  // The read word is cleared at grant and never written by stores, so stores
  // return 0.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    dbg_state = state_q;
    if_done   = ((state_q == ST_RESP) || (state_q == ST_ERR)) && (owner_q == OWNER_IF);
    dm_done   = ((state_q == ST_RESP) || (state_q == ST_ERR)) && (owner_q == OWNER_DM);
    if_err    = (state_q == ST_ERR) && (owner_q == OWNER_IF);
    dm_err    = (state_q == ST_ERR) && (owner_q == OWNER_DM);
    if_rdata  = ((state_q == ST_RESP) && (owner_q == OWNER_IF)) ? seq_rdata : 32'h0;
    dm_rdata  = ((state_q == ST_RESP) && (owner_q == OWNER_DM)) ? seq_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MEM_DEPTH = 1024;
  localparam int MADDR_W   = 10;

  logic               clk;
  logic               rst_n;
  logic               if_req;
  logic [31:0]        if_addr;
  logic               if_done;
  logic [31:0]        if_rdata;
  logic               if_err;
  logic               dm_req;
  logic               dm_we;
  logic [31:0]        dm_addr;
  logic [31:0]        dm_wdata;
  logic               dm_done;
  logic [31:0]        dm_rdata;
  logic               dm_err;
  logic [MADDR_W-1:0] mem_addr;
  logic               mem_we;
  logic [7:0]         mem_wbyte;
  logic [7:0]         mem_rbyte;
  logic               busy;
  logic [1:0]         dbg_state;

  mem_port_arbiter #(
    .MEM_DEPTH  (MEM_DEPTH),
    .MADDR_W    (MADDR_W),
    .STARVE_MAX (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wbyte (mem_wbyte),
    .mem_rbyte (mem_rbyte),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory array attached to the DUT ----------------
  logic [7:0] mem [0:MEM_DEPTH-1];
  logic       mem_init;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= init_byte(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wbyte;
    end
  end
  assign mem_rbyte = mem[mem_addr];

  // ---------------- reference model state ----------------
  logic [7:0]  ref_mem [0:MEM_DEPTH-1];
  int          starve_m;
  bit          if_pend, dm_pend;
  logic [31:0] if_a, dm_a, dm_wd;
  bit          dm_w;
  bit          last_win_if;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a > MEM_DEPTH - 4);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [9:0] b;
    b = a[9:0];
    return {ref_mem[b], ref_mem[b+10'd1], ref_mem[b+10'd2], ref_mem[b+10'd3]};
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
    if (r == 1) return 32'(MEM_DEPTH - 4 + 4 * $urandom_range(1, 500));
    return 32'(4 * $urandom_range(0, 255));
  endfunction

  // One arbitration round: drive the pending requests in an IDLE cycle,
  // predict the winner and its response, and check everything up to the
  // cycle after its done pulse.
  task automatic do_round(input string tag);
    bit          win_if, seen, exp_err, exp_we;
    logic [31:0] addr, exp_rd, wd;
    int          n, we_cnt, busy_low, exp_lat;
    @(negedge clk);
    if_req   = if_pend;
    if_addr  = if_a;
    dm_req   = dm_pend;
    dm_addr  = dm_a;
    dm_we    = dm_w;
    dm_wdata = dm_wd;
    win_if = if_pend && (!dm_pend || starve_m == 3);
    if (!if_pend || win_if) starve_m = 0;
    else if (starve_m < 3) starve_m++;
    last_win_if = win_if;
    addr    = win_if ? if_a : dm_a;
    exp_we  = win_if ? 1'b0 : dm_w;
    wd      = dm_wd;
    exp_err = ref_illegal(addr);
    exp_lat = exp_err ? 1 : 5;
    exp_rd  = (exp_err || exp_we) ? 32'h0 : ref_word(addr);
    @(posedge clk);
    seen = 0; n = 0; we_cnt = 0; busy_low = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (mem_we) we_cnt++;
      if (!busy) busy_low++;
      if (if_done || dm_done) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_winner"}, {30'd0, if_done, dm_done}, win_if ? 32'd2 : 32'd1);
      chk({tag, "_rdata"}, win_if ? if_rdata : dm_rdata, exp_rd);
      chk({tag, "_err"}, 32'(win_if ? if_err : dm_err), 32'(exp_err));
      chk({tag, "_other_rdata"}, win_if ? dm_rdata : if_rdata, 32'h0);
      chk({tag, "_pins_idle"}, {13'd0, mem_we, mem_wbyte, mem_addr}, 32'h0);
    end
    chk({tag, "_busy_low"}, 32'(busy_low), 32'd0);
    chk({tag, "_we_beats"}, 32'(we_cnt), (exp_we && !exp_err) ? 32'd4 : 32'd0);
    if (win_if) begin
      if_pend = 0; if_req = 1'b0;
    end else begin
      dm_pend = 0; dm_req = 1'b0;
    end
    if (exp_we && !exp_err) begin
      for (int k = 0; k < 4; k++) ref_mem[addr[9:0] + 10'(k)] = wd[31-8*k -: 8];
    end
    @(posedge clk);
    #1;
    chk({tag, "_after"}, {29'd0, if_done, dm_done, busy}, 32'h0);
  endtask

  task automatic chk_bytes(input string tag, input int base, input int len);
    for (int k = 0; k < len; k++) begin
      chk($sformatf("%s_byte%0d", tag, base + k), 32'(mem[base + k]), 32'(ref_mem[base + k]));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [4:0] win_seq;
    checks = 0; errors = 0; starve_m = 0;
    if_pend = 0; dm_pend = 0; if_a = 0; dm_a = 0; dm_w = 0; dm_wd = 0;
    rst_n = 1'b0; mem_init = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_byte(i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done_err", {28'd0, if_done, if_err, dm_done, dm_err}, 32'h0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
    chk("rst_pins", {13'd0, mem_we, mem_wbyte, mem_addr}, 32'h0);
    chk("rst_busy", {30'd0, busy, 1'b0} | 32'(dbg_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; mem_init = 1'b0;

    // 1: DM store
    dm_pend = 1; dm_a = 32'd8; dm_w = 1; dm_wd = 32'h11223344;
    do_round("t1");
    chk("t1_mem", {mem[8], mem[9], mem[10], mem[11]}, 32'h11223344);

    // 2: IF load of the same word
    if_pend = 1; if_a = 32'd8;
    do_round("t2");

    // 3: both requesting, DM back-to-back, IF forced after 3 DM grants
    dm_pend = 1; dm_a = 32'd100; dm_w = 1; dm_wd = $urandom;
    if_pend = 1; if_a = 32'd40;
    for (int r = 0; r < 5; r++) begin
      do_round($sformatf("t3_r%0d", r));
      win_seq[4-r] = last_win_if;
      if (!dm_pend && r < 4) begin
        dm_pend = 1; dm_a = 32'(4 * $urandom_range(0, 255)); dm_w = $urandom_range(0, 1); dm_wd = $urandom;
      end
      if (!if_pend) begin
        if_pend = 1; if_a = 32'(4 * $urandom_range(0, 255));
      end
    end
    chk("t3_grant_order", 32'(win_seq), 32'b00010);
    while (if_pend || dm_pend) do_round("t3_drain");

    // 4: illegal DM addresses
    dm_pend = 1; dm_a = 32'd6; dm_w = 1; dm_wd = 32'hDEADBEEF;
    do_round("t4_mis");
    dm_pend = 1; dm_a = 32'd1021; dm_w = 1; dm_wd = 32'hCAFEF00D;
    do_round("t4_oor");
    chk_bytes("t4", 1016, 8);

    // 5: reset during beat 2 of a store
    @(negedge clk);
    dm_req = 1; dm_we = 1; dm_addr = 32'd16; dm_wdata = 32'hAABBCCDD;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t5_nodone%0d", c), {30'd0, if_done, dm_done}, 32'h0);
    end
    rst_n = 1'b0;
    #1;
    chk("t5_pins", {13'd0, mem_we, mem_wbyte, mem_addr}, 32'h0);
    chk("t5_busy", {29'd0, busy, if_done, dm_done}, 32'h0);
    chk("t5_rdata", if_rdata | dm_rdata, 32'h0);
    dm_req = 0; starve_m = 0;
    ref_mem[16] = 8'hAA; ref_mem[17] = 8'hBB;
    repeat (2) begin
      @(negedge clk);
      chk("t5_held", {29'd0, busy, if_done, dm_done}, 32'h0);
    end
    rst_n = 1'b1;
    chk_bytes("t5", 16, 4);

    // 6: IF load of an instruction word
    dm_pend = 1; dm_a = 32'h1A0; dm_w = 1; dm_wd = 32'h01285020;
    do_round("t6_store");
    if_pend = 1; if_a = 32'h1A0;
    do_round("t6_load");

    // random traffic against the model
    for (int r = 0; r < 60; r++) begin
      if (!if_pend && $urandom_range(0, 1) == 1) begin
        if_pend = 1; if_a = rand_addr();
      end
      if (!dm_pend && $urandom_range(0, 2) != 0) begin
        dm_pend = 1; dm_a = rand_addr(); dm_w = $urandom_range(0, 1); dm_wd = $urandom;
      end
      if (!if_pend && !dm_pend) begin
        dm_pend = 1; dm_a = rand_addr(); dm_w = 0; dm_wd = 0;
      end
      do_round($sformatf("rnd%0d", r));
    end
    while (if_pend || dm_pend) do_round("rnd_drain");

    chk_bytes("final", 0, MEM_DEPTH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
